alu_resp_unit: RTL and testbench

ALU_RESP_UNIT -- requirements
Module: alu_resp_unit

---
 rtl/alu_pkg.sv | 47 ++++
 rtl/alu_decode.sv | 58 +++++
 rtl/alu_resp_unit.sv | 166 ++++++++++++++++
 tb/tb_alu_resp_unit.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared MIPS OpCode/Funct constants and the ALU control
// enumeration used by the decoder and the response-unit datapath.
package alu_pkg;

    // OpCode field values
    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_ADDIU = 6'd9;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_SLTIU = 6'd11;
    localparam logic [5:0] OP_ANDI  = 6'd12;
    localparam logic [5:0] OP_LUI   = 6'd15;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    // Funct field values (meaningful only when OpCode is OP_RTYPE)
    localparam logic [5:0] FN_SLL  = 6'd0;
    localparam logic [5:0] FN_SRL  = 6'd2;
    localparam logic [5:0] FN_SRA  = 6'd3;
    localparam logic [5:0] FN_ADD  = 6'd32;
    localparam logic [5:0] FN_ADDU = 6'd33;
    localparam logic [5:0] FN_SUB  = 6'd34;
    localparam logic [5:0] FN_SUBU = 6'd35;
    localparam logic [5:0] FN_AND  = 6'd36;
    localparam logic [5:0] FN_OR   = 6'd37;
    localparam logic [5:0] FN_XOR  = 6'd38;
    localparam logic [5:0] FN_NOR  = 6'd39;
    localparam logic [5:0] FN_SLT  = 6'd42;
    localparam logic [5:0] FN_SLTU = 6'd43;

    // ALU operation selected by the decoder
    typedef enum logic [3:0] {
        CTL_ADD,
        CTL_SUB,
        CTL_AND,
        CTL_OR,
        CTL_XOR,
        CTL_NOR,
        CTL_SLL,
        CTL_SRL,
        CTL_SRA,
        CTL_LUI,
        CTL_SLT
    } alu_ctl_e;

endpackage

// File: rtl/alu_decode.sv
// alu_decode: combinational OpCode/Funct decoder.
// Ports:
//   opcode  - MIPS OpCode field
//   funct   - MIPS Funct field (used only for R-type)
//   alu_ctl - selected ALU operation
//   sign    - 1: set-less-than compares signed, 0: unsigned
//   ovf_en  - signed overflow is reported for this operation
//   err     - unsupported OpCode/Funct combination
module alu_decode
    import alu_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output alu_ctl_e   alu_ctl,
    output logic       sign,
    output logic       ovf_en,
    output logic       err
);

    always_comb begin
        alu_ctl = CTL_ADD;
        sign    = 1'b1;
        ovf_en  = 1'b0;
        err     = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  ovf_en = 1'b1;
                    FN_ADDU: begin end
                    FN_SUB:  begin alu_ctl = CTL_SUB; ovf_en = 1'b1; end
                    FN_SUBU: alu_ctl = CTL_SUB;
                    FN_AND:  alu_ctl = CTL_AND;
                    FN_OR:   alu_ctl = CTL_OR;
                    FN_XOR:  alu_ctl = CTL_XOR;
                    FN_NOR:  alu_ctl = CTL_NOR;
                    FN_SLL:  alu_ctl = CTL_SLL;
                    FN_SRL:  alu_ctl = CTL_SRL;
                    FN_SRA:  alu_ctl = CTL_SRA;
                    FN_SLT:  alu_ctl = CTL_SLT;
                    FN_SLTU: begin alu_ctl = CTL_SLT; sign = 1'b0; end
                    default: err = 1'b1;
                endcase
            end
            // Address generation for loads/stores wraps silently
            OP_LW, OP_SW: begin end
            OP_ADDI:  ovf_en = 1'b1;
            OP_ADDIU: begin end
            // Branch compare: subtraction result only, never flags overflow
            OP_BEQ:   alu_ctl = CTL_SUB;
            OP_ANDI:  alu_ctl = CTL_AND;
            OP_LUI:   alu_ctl = CTL_LUI;
            OP_SLTI:  alu_ctl = CTL_SLT;
            OP_SLTIU: begin alu_ctl = CTL_SLT; sign = 1'b0; end
            default:  err = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_resp_unit.sv
// alu_resp_unit: two-stage valid/ready MIPS ALU.
// S1 registers the decoded control and operands, S2 registers the result.
// Ports:
//   clk, reset          - rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready - request handshake
//   req_opcode/funct    - MIPS OpCode / Funct
//   req_in1/req_in2     - operands (in1 supplies the shift amount)
//   rsp_valid/rsp_ready - response handshake
//   rsp_out/zero/ovf/err - result, result==0, signed overflow, unsupported op
module alu_resp_unit
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [5:0]        req_opcode,
    input  logic [5:0]        req_funct,
    input  logic [DATA_W-1:0] req_in1,
    input  logic [DATA_W-1:0] req_in2,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_out,
    output logic              rsp_zero,
    output logic              rsp_ovf,
    output logic              rsp_err
);

    function automatic logic [DATA_W-1:0] alu_calc(
        input alu_ctl_e          ctl,
        input logic              sign,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic signed [DATA_W-1:0] sa;
        logic signed [DATA_W-1:0] sb;
        logic                     lt;
        sa = a;
        sb = b;
        lt = sign ? (sa < sb) : (a < b);
        case (ctl)
            CTL_ADD: return a + b;
            CTL_SUB: return a - b;
            CTL_AND: return a & b;
            CTL_OR:  return a | b;
            CTL_XOR: return a ^ b;
            CTL_NOR: return ~(a | b);
            CTL_SLL: return b << a[4:0];
            CTL_SRL: return b >> a[4:0];
            CTL_SRA: return sb >>> a[4:0];
            CTL_LUI: return {a[15:0], 16'h0000};
            CTL_SLT: return {{(DATA_W-1){1'b0}}, lt};
            default: return '0;
        endcase
    endfunction

    // Signed overflow: operands that agree in sign (add) or differ in sign
    // (sub) must not produce a result whose sign differs from operand a.
    function automatic logic ovf_detect(
        input alu_ctl_e          ctl,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input logic [DATA_W-1:0] r
    );
        if (ctl == CTL_SUB)
            return (a[DATA_W-1] != b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
        return (a[DATA_W-1] == b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
    endfunction

    alu_ctl_e ctl_dec;
    logic     sign_dec;
    logic     ovf_en_dec;
    logic     err_dec;

    alu_decode u_decode (
        .opcode  (req_opcode),
        .funct   (req_funct),
        .alu_ctl (ctl_dec),
        .sign    (sign_dec),
        .ovf_en  (ovf_en_dec),
        .err     (err_dec)
    );

    logic              vld_p1;
    alu_ctl_e          ctl_p1;
    logic              sign_p1;
    logic              ovf_en_p1;
    logic              err_p1;
    logic [DATA_W-1:0] in1_p1;
    logic [DATA_W-1:0] in2_p1;

    logic              vld_p2;
    logic [DATA_W-1:0] out_p2;
    logic              zero_p2;
    logic              ovf_p2;
    logic              err_p2;

    logic              adv_p1;
    logic              adv_p2;
    logic [DATA_W-1:0] res_c;
    logic              ovf_c;

    // S2 can take new data when empty or its result is being consumed;
    // S1 moves forward only when it holds something and S2 can take it.
    assign adv_p2    = !vld_p2 || rsp_ready;
    assign adv_p1    = vld_p1 && adv_p2;
    assign req_ready = !vld_p1 || adv_p1;

    // ---- Stage S1: decoded control + operands ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            vld_p1 <= 1'b0;
        else if (req_ready)
            vld_p1 <= req_valid;
    end

    always_ff @(posedge clk) begin
        if (req_ready && req_valid) begin
            ctl_p1    <= ctl_dec;
            sign_p1   <= sign_dec;
            ovf_en_p1 <= ovf_en_dec;
            err_p1    <= err_dec;
            in1_p1    <= req_in1;
            in2_p1    <= req_in2;
        end
    end

    // Unsupported operations produce a zero result with no overflow
    always_comb begin
        res_c = '0;
        ovf_c = 1'b0;
        if (!err_p1) begin
            res_c = alu_calc(ctl_p1, sign_p1, in1_p1, in2_p1);
            ovf_c = ovf_en_p1 && ovf_detect(ctl_p1, in1_p1, in2_p1, res_c);
        end
    end

    // ---- Stage S2: registered result ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p2  <= 1'b0;
            out_p2  <= '0;
            zero_p2 <= 1'b0;
            ovf_p2  <= 1'b0;
            err_p2  <= 1'b0;
        end else begin
            if (adv_p2)
                vld_p2 <= vld_p1;
            if (adv_p1) begin
                out_p2  <= res_c;
                zero_p2 <= (res_c == '0);
                ovf_p2  <= ovf_c;
                err_p2  <= err_p1;
            end
        end
    end

    assign rsp_valid = vld_p2;
    assign rsp_out   = out_p2;
    assign rsp_zero  = zero_p2;
    assign rsp_ovf   = ovf_p2;
    assign rsp_err   = err_p2;

endmodule

// File: tb/tb_alu_resp_unit.sv
module tb_alu_resp_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_opcode;
    logic [5:0]  req_funct;
    logic [31:0] req_in1;
    logic [31:0] req_in2;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_out;
    logic        rsp_zero;
    logic        rsp_ovf;
    logic        rsp_err;

    alu_resp_unit #(.DATA_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_opcode (req_opcode),
        .req_funct  (req_funct),
        .req_in1    (req_in1),
        .req_in2    (req_in2),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_out    (rsp_out),
        .rsp_zero   (rsp_zero),
        .rsp_ovf    (rsp_ovf),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] out;
        logic        zero;
        logic        ovf;
        logic        err;
    } exp_t;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] out;
        logic        zero;
        logic        ovf;
        logic        err;
    } vec_t;

    localparam int NVEC = 23;
    vec_t vecs[NVEC];
    exp_t sb_q[$];

    int checks = 0;
    int errors = 0;
    int n_acc  = 0;
    int rsp_n  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Response monitor: compares every completed response against the
    // scoreboard and checks outputs stay put while backpressured.
    initial begin : monitor
        exp_t        e;
        logic        hold_pend;
        logic [34:0] hold_val;
        hold_pend = 1'b0;
        hold_val  = '0;
        forever begin
            @(negedge clk);
            if (rsp_valid && hold_pend)
                chk($sformatf("hold_stable[%0d]", rsp_n), {rsp_out, rsp_zero, rsp_ovf, rsp_err}, hold_val);
            if (rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_rsp", 64'd1, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk($sformatf("rsp_out[%0d]", rsp_n),  rsp_out,  e.out);
                    chk($sformatf("rsp_zero[%0d]", rsp_n), rsp_zero, e.zero);
                    chk($sformatf("rsp_ovf[%0d]", rsp_n),  rsp_ovf,  e.ovf);
                    chk($sformatf("rsp_err[%0d]", rsp_n),  rsp_err,  e.err);
                end
                rsp_n++;
                hold_pend = 1'b0;
            end else if (rsp_valid) begin
                hold_pend = 1'b1;
                hold_val  = {rsp_out, rsp_zero, rsp_ovf, rsp_err};
            end else begin
                hold_pend = 1'b0;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [5:0] op, input logic [5:0] fn,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eo, input logic ez,
                        input logic eov, input logic eer);
        bit acc;
        int budget;
        req_valid  = 1'b1;
        req_opcode = op;
        req_funct  = fn;
        req_in1    = a;
        req_in2    = b;
        acc        = 1'b0;
        budget     = 0;
        while (!acc) begin
            @(negedge clk);
            acc = req_ready;
            if (acc) begin
                sb_q.push_back('{eo, ez, eov, eer});
                n_acc++;
            end
            @(posedge clk);
            #1;
            budget++;
            if (!acc && budget > 50) begin
                chk("req_accept_timeout", 64'd0, 64'd1);
                break;
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (sb_q.size() != 0 && budget < 50) begin
            @(posedge clk);
            #1;
            budget++;
        end
        if (sb_q.size() != 0)
            chk("drain_timeout", sb_q.size(), 64'd0);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        time t0;
        time t1;
        int  acc_base;

        vecs = '{
            '{6'd0,  6'd32, 32'hFFFFFFE3, 32'h0000000B, 32'hFFFFFFEE, 1'b0, 1'b0, 1'b0},
            '{6'd0,  6'd34, 32'd10,       32'd10,       32'h00000000, 1'b1, 1'b0, 1'b0},
            '{6'd4,  6'd0,  32'd11,       32'd11,       32'h00000000, 1'b1, 1'b0, 1'b0},
            '{6'd8,  6'd0,  32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b0, 1'b1, 1'b0},
            '{6'd9,  6'd0,  32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b0, 1'b0, 1'b0},
            '{6'd0,  6'd33, 32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b0, 1'b0, 1'b0},
            '{6'd0,  6'd34, 32'h80000000, 32'd1,        32'h7FFFFFFF, 1'b0, 1'b1, 1'b0},
            '{6'd0,  6'd35, 32'h80000000, 32'd1,        32'h7FFFFFFF, 1'b0, 1'b0, 1'b0},
            '{6'd35, 6'd0,  32'd100,      32'd4,        32'd104,      1'b0, 1'b0, 1'b0},
            '{6'd0,  6'd3,  32'd4,        32'h80000000, 32'hF8000000, 1'b0, 1'b0, 1'b0},
            '{6'd0,  6'd2,  32'd4,        32'h80000000, 32'h08000000, 1'b0, 1'b0, 1'b0},
            '{6'd0,  6'd0,  32'd36,       32'd1,        32'h00000010, 1'b0, 1'b0, 1'b0},
            '{6'd11, 6'd0,  32'd3,        32'd2,        32'h00000000, 1'b1, 1'b0, 1'b0},
            '{6'd0,  6'd43, 32'd1,        32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0},
            '{6'd0,  6'd42, 32'hFFFFFFFF, 32'd1,        32'h00000001, 1'b0, 1'b0, 1'b0},
            '{6'd10, 6'd0,  32'd5,        32'hFFFFFFFD, 32'h00000000, 1'b1, 1'b0, 1'b0},
            '{6'd15, 6'd0,  32'd6664,     32'd0,        32'h1A080000, 1'b0, 1'b0, 1'b0},
            '{6'd12, 6'd0,  32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0, 1'b0, 1'b0},
            '{6'd63, 6'd0,  32'd5,        32'd5,        32'h00000000, 1'b1, 1'b0, 1'b1},
            '{6'd0,  6'd1,  32'd5,        32'd5,        32'h00000000, 1'b1, 1'b0, 1'b1},
            '{6'd0,  6'd39, 32'd0,        32'd0,        32'hFFFFFFFF, 1'b0, 1'b0, 1'b0},
            '{6'd43, 6'd0,  32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b0, 1'b0, 1'b0},
            '{6'd0,  6'd32, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1, 1'b0}
        };

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_opcode = '0;
        req_funct  = '0;
        req_in1    = '0;
        req_in2    = '0;
        rsp_ready  = 1'b1;

        // Outputs while reset is held
        #12;
        chk("reset_rsp_valid", rsp_valid, 64'd0);
        chk("reset_req_ready", req_ready, 64'd1);
        chk("reset_rsp_out",   rsp_out,   64'd0);
        chk("reset_rsp_zero",  rsp_zero,  64'd0);
        chk("reset_rsp_ovf",   rsp_ovf,   64'd0);
        chk("reset_rsp_err",   rsp_err,   64'd0);

        @(posedge clk);
        #1;
        reset = 1'b0;

        // Latency: first edge after reset accepts, rsp_valid two cycles later
        chk("first_req_ready", req_ready, 64'd1);
        req_valid  = 1'b1;
        req_opcode = 6'd0;
        req_funct  = 6'd32;
        req_in1    = 32'hFFFFFFE3;
        req_in2    = 32'd11;
        sb_q.push_back('{32'hFFFFFFEE, 1'b0, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("latency_cycle1_valid", rsp_valid, 64'd0);
        @(posedge clk);
        #1;
        chk("latency_cycle2_valid", rsp_valid, 64'd1);
        drain();

        // Table vectors, back-to-back at full throughput
        t0 = $time;
        for (int i = 0; i < NVEC; i++)
            send(vecs[i].op, vecs[i].fn, vecs[i].a, vecs[i].b,
                 vecs[i].out, vecs[i].zero, vecs[i].ovf, vecs[i].err);
        t1 = $time;
        chk("throughput_cycles", (t1 - t0) / 10, NVEC);
        drain();

        // Backpressure: four logic ops with rsp_ready low for five cycles
        rsp_ready = 1'b0;
        acc_base  = n_acc;
        fork
            begin
                send(6'd0, 6'd36, 32'd44, 32'd23, 32'h00000004, 1'b0, 1'b0, 1'b0);
                send(6'd0, 6'd37, 32'd44, 32'd23, 32'h0000003F, 1'b0, 1'b0, 1'b0);
                send(6'd0, 6'd38, 32'd44, 32'd23, 32'h0000003B, 1'b0, 1'b0, 1'b0);
                send(6'd0, 6'd39, 32'd44, 32'd23, 32'hFFFFFFC0, 1'b0, 1'b0, 1'b0);
            end
            begin
                repeat (3) @(negedge clk);
                chk("bp_req_ready_low", req_ready, 64'd0);
                chk("bp_accepts", n_acc - acc_base, 64'd2);
                repeat (2) @(posedge clk);
                #1;
                rsp_ready = 1'b1;
            end
        join
        drain();

        // Reset with two requests in flight
        rsp_ready  = 1'b0;
        req_valid  = 1'b1;
        req_opcode = 6'd8;
        req_funct  = 6'd0;
        req_in1    = 32'h7FFFFFFF;
        req_in2    = 32'd1;
        @(posedge clk);
        #1;
        req_opcode = 6'd0;
        req_funct  = 6'd37;
        req_in1    = 32'd44;
        req_in2    = 32'd23;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("inflight_valid_before_reset", rsp_valid, 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("inflight_reset_rsp_valid", rsp_valid, 64'd0);
        chk("inflight_reset_rsp_out",   rsp_out,   64'd0);
        chk("inflight_reset_rsp_ovf",   rsp_ovf,   64'd0);
        chk("inflight_reset_req_ready", req_ready, 64'd1);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("no_stale_rsp[%0d]", i), rsp_valid, 64'd0);
        end

        // Normal operation resumes after reset
        send(6'd0, 6'd34, 32'd10, 32'd3, 32'd7, 1'b0, 1'b0, 1'b0);
        drain();
        repeat (3) @(posedge clk);
        chk("scoreboard_empty", sb_q.size(), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
